// File: rtl/axi_rd_sram_slave_pkg.sv
// Shared types and constants for the AXI4 read-channel SRAM responder.
//   state_t     : burst FSM encoding (IDLE / BURST)
//   RRESP_OKAY  : only response code this slave ever returns
//   BURST_*     : AXI arburst codes
//   wrap_mask() : word-offset mask for a legal WRAP length, 0 otherwise
package axi_rd_sram_slave_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [1:0] RRESP_OKAY = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    // R buffer is fixed at two entries: one being drained, one landing from SRAM.
    localparam int FIFO_DEPTH = 2;
    localparam int BEAT_W     = 33;   // {last, data[31:0]}

    // WRAP is only legal for 2/4/8/16 beats; anything else degrades to INCR,
    // signalled by a zero mask.
    function automatic logic [7:0] wrap_mask(input logic [7:0] len);
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: wrap_mask = len;
            default:                 wrap_mask = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/axi_rd_sram_slave_rd_skid_fifo.sv
// rd_skid_fifo: 2-entry FIFO holding R beats ({last, data}) between the SRAM
// read port and the R channel.
//   clk, rst        : clock, async active-low reset
//   push, push_data : write one beat (caller guarantees count < 2)
//   pop             : drop head beat (caller guarantees count > 0)
//   head            : current head beat, stable until popped
//   count           : occupancy 0..2
module rd_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [1:0][WIDTH-1:0] mem;
    logic                  wr_ptr;
    logic                  rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_sram_slave.sv
// axi_rd_sram_slave: AXI4 read-channel slave in front of a synchronous
// single-port SRAM (1-cycle read latency). One burst outstanding at a time;
// R channel fully honours rready backpressure via a 2-entry buffer and a
// credit check on SRAM issue.
//   clk, rst                 : clock, async active-low reset
//   araddr/arlen/arvalid/arready : AR channel (araddr[1:0] ignored)
//   arburst                  : only present when AXI_RD_WRAP_EN is defined
//   rdata/rresp/rlast/rvalid/rready : R channel, rresp always OKAY
//   sram_en/sram_addr/sram_rdata    : SRAM read port
// Build option: define AXI_RD_WRAP_EN to add arburst and WRAP bursts.
module axi_rd_sram_slave
    import axi_rd_sram_slave_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic              arvalid,
    output logic              arready,
`ifdef AXI_RD_WRAP_EN
    input  logic [1:0]        arburst,
`endif
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    output logic              sram_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [31:0]       sram_rdata
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   base;
    logic [8:0]          total;
    logic [8:0]          issued;
    logic                inflight;
    logic                inflight_last;
    logic [1:0]          fifo_count;
    logic [BEAT_W-1:0]   head;
    logic                pop;
    logic                has_credit;
    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   incr_addr;
    logic                unused_araddr;

    assign unused_araddr = ^{araddr[31:ADDR_W+2], araddr[1:0]};

    // R channel straight off the buffer head
    assign rvalid = (fifo_count != 2'd0);
    assign rdata  = head[31:0];
    assign rlast  = head[32] & rvalid;
    assign rresp  = RRESP_OKAY;
    assign pop    = rvalid & rready;

    // Issue only if the beat has a guaranteed slot: buffered + in-flight beats
    // must stay below 2, counting a slot freed by this cycle's pop.
    assign has_credit = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    assign offset    = ADDR_W'(issued);
    assign incr_addr = base + offset;

`ifdef AXI_RD_WRAP_EN
    logic [ADDR_W-1:0] wmask;

    // Zero mask means INCR; otherwise the low bits cycle inside the aligned block.
    assign sram_addr = (wmask == '0) ? incr_addr
                                     : ((base & ~wmask) | (incr_addr & wmask));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wmask <= '0;
        end else if (state == ST_IDLE && arvalid) begin
            wmask <= (arburst == BURST_WRAP) ? ADDR_W'(wrap_mask(arlen)) : '0;
        end
    end
`else
    assign sram_addr = incr_addr;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arvalid)         state_nxt = ST_BURST;
            ST_BURST: if (pop && head[32]) state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        arready = 1'b0;
        sram_en = 1'b0;
        case (state)
            ST_IDLE:  arready = 1'b1;
            ST_BURST: sram_en = (issued < total) && has_credit;
            default:  ;
        endcase
    end

    // Burst bookkeeping and the one-cycle SRAM latency tracker
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base          <= '0;
            total         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                if (arvalid) begin
                    base  <= araddr[ADDR_W+1:2];
                    total <= {1'b0, arlen} + 9'd1;
                end
                issued <= '0;
            end else if (sram_en) begin
                issued <= issued + 9'd1;
            end
            inflight      <= sram_en;
            inflight_last <= sram_en && (issued == total - 9'd1);
        end
    end

    rd_skid_fifo #(
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({inflight_last, sram_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_axi_rd_sram_slave.sv
`timescale 1ns/1ps
module tb_axi_rd_sram_slave;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef AXI_RD_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       araddr = '0;
    logic [7:0]        arlen = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [1:0]        arburst = 2'b01;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready = 1'b0;
    logic              sram_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_rdata = '0;

    logic [31:0] mem [DEPTH];

    always #5 clk = ~clk;

    axi_rd_sram_slave #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .araddr     (araddr),
        .arlen      (arlen),
        .arvalid    (arvalid),
        .arready    (arready),
`ifdef AXI_RD_WRAP_EN
        .arburst    (arburst),
`endif
        .rdata      (rdata),
        .rresp      (rresp),
        .rlast      (rlast),
        .rvalid     (rvalid),
        .rready     (rready),
        .sram_en    (sram_en),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata)
    );

    // SRAM: data appears the cycle after the enable
    always @(posedge clk) if (sram_en) sram_rdata <= mem[sram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // rready pattern: 0 always ready, 1 toggle, 2 random
    int rmode = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       rready = 1'b1;
            1:       rready = ~rready;
            default: rready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          exp_addr[$];
    int          addr_log[$];
    logic [31:0] data_log[$];
    bit          busy = 0;
    int          issued = 0;
    int          popped = 0;
    int          hs_cyc = 0, first_rv_cyc = -1, last_pop_cyc = -1, ar_back_cyc = -1;
    bit          want_back = 0;
    logic [31:0] first_rdata;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;
    int          m_idx, m_n, m_a;
    bit          m_wrap;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_rvalid", rvalid, 0);
            chk("rst_arready", arready, 1);
            chk("rst_sram_en", sram_en, 0);
            chk("rst_rlast", rlast, 0);
            chk("rst_rdata", rdata, 0);
            exp_q.delete();
            exp_addr.delete();
            busy = 0; issued = 0; popped = 0; prev_stall = 0; want_back = 0;
        end else begin
            chk("arready", arready, !busy);
            chk("rresp", rresp, 0);
            if (want_back && arready && !busy) begin
                ar_back_cyc = cyc;
                want_back   = 0;
            end
            if (prev_stall) begin
                chk("stall_rvalid", rvalid, 1);
                chk("stall_rdata", rdata, prev_data);
                chk("stall_rlast", rlast, prev_last);
            end
            if (sram_en) begin
                if (issued >= exp_addr.size()) chk("sram_en_extra", sram_en, 0);
                else begin
                    chk("sram_addr", sram_addr, exp_addr[issued]);
                    // beats issued but not yet drained, minus this cycle's pop
                    chk("credit", (issued - popped - int'(rvalid && rready)) < 2, 1);
                end
                addr_log.push_back(int'(sram_addr));
                issued++;
            end
            if (rvalid) begin
                if (exp_q.size() == 0) chk("spurious_rvalid", rvalid, 0);
                else begin
                    chk("rdata", rdata, exp_q[0].d);
                    chk("rlast", rlast, exp_q[0].last);
                    if (first_rv_cyc < 0) begin
                        first_rv_cyc = cyc;
                        first_rdata  = rdata;
                    end
                    if (rready) begin
                        data_log.push_back(rdata);
                        if (exp_q[0].last) begin
                            last_pop_cyc = cyc;
                            busy         = 0;
                        end
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
            if (arvalid && arready) begin
                m_idx  = int'(araddr[ADDR_W+1:2]);
                m_n    = int'(arlen) + 1;
                m_wrap = WRAP_EN && arburst == 2'b10 &&
                         (m_n == 2 || m_n == 4 || m_n == 8 || m_n == 16);
                exp_q.delete(); exp_addr.delete(); addr_log.delete(); data_log.delete();
                for (int i = 0; i < m_n; i++) begin
                    if (m_wrap) m_a = (m_idx - m_idx % m_n) + (m_idx % m_n + i) % m_n;
                    else        m_a = (m_idx + i) % DEPTH;
                    exp_addr.push_back(m_a);
                    exp_q.push_back('{d: mem[m_a], last: (i == m_n - 1)});
                end
                busy = 1; issued = 0; popped = 0;
                hs_cyc = cyc; first_rv_cyc = -1; last_pop_cyc = -1; ar_back_cyc = -1;
                want_back = 1;
            end
            prev_stall = rvalid && !rready;
            prev_data  = rdata;
            prev_last  = rlast;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b);
        int t = 0;
        @(posedge clk); #1;
        araddr = a; arlen = len; arburst = b; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && t < 200) begin @(negedge clk); t++; end
        chk("ar_accept", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        araddr  = $urandom;
        arlen   = 8'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (busy && t < 3000) begin @(negedge clk); t++; end
        @(negedge clk);
        chk("burst_done_arready", arready, 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = i;
        mem[5] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);

        // single beat
        rmode = 0;
        do_ar(32'h14, 8'd0, 2'b01);
        wait_done();
        chk("t1_rvalid_lat", first_rv_cyc - hs_cyc, 3);
        chk("t1_rdata", first_rdata, 32'hDEADBEEF);
        chk("t1_last_cyc", last_pop_cyc - hs_cyc, 3);
        chk("t1_arready_back", ar_back_cyc - hs_cyc, 4);

        // INCR burst of 4
        do_ar(32'h40, 8'd3, 2'b01);
        wait_done();
        chk("t2_nbeats", data_log.size(), 4);
        chk("t2_beat0", data_log[0], 32'h10);
        chk("t2_beat3", data_log[3], 32'h13);
        chk("t2_rvalid_lat", first_rv_cyc - hs_cyc, 3);
        chk("t2_last_cyc", last_pop_cyc - hs_cyc, 6);
        chk("t2_arready_back", ar_back_cyc - hs_cyc, 7);

        // toggling backpressure
        rmode = 1;
        do_ar(32'h80, 8'd7, 2'b01);
        wait_done();
        chk("t3_nbeats", data_log.size(), 8);
        chk("t3_beat7", data_log[7], 32'h27);

        // wrap at top of SRAM
        rmode = 0;
        do_ar(32'h3FF8, 8'd3, 2'b01);
        wait_done();
        chk("t4_addr0", addr_log[0], 4094);
        chk("t4_addr1", addr_log[1], 4095);
        chk("t4_addr2", addr_log[2], 0);
        chk("t4_addr3", addr_log[3], 1);

        // reset in the middle of a 16-beat burst
        begin
            int t = 0;
            do_ar(32'h0, 8'd15, 2'b01);
            while (popped < 4 && t < 200) begin @(posedge clk); t++; end
            #1 rst = 1'b0;
            @(negedge clk);
            chk("t5_rst_rvalid", rvalid, 0);
            chk("t5_rst_arready", arready, 1);
            @(posedge clk); #1 rst = 1'b1;
            repeat (6) @(posedge clk);
            mem[7] = 32'hCAFEF00D;
            do_ar(32'h1C, 8'd0, 2'b01);
            wait_done();
            chk("t5_new_rdata", first_rdata, 32'hCAFEF00D);
            chk("t5_new_nbeats", data_log.size(), 1);
        end

`ifdef AXI_RD_WRAP_EN
        do_ar(32'h48, 8'd3, 2'b10);
        wait_done();
        chk("t6_addr0", addr_log[0], 18);
        chk("t6_addr1", addr_log[1], 19);
        chk("t6_addr2", addr_log[2], 16);
        chk("t6_addr3", addr_log[3], 17);
`endif

        // randomized bursts
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] len;
            rmode = int'($urandom_range(0, 2));
            len   = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(0, 15));
            do_ar($urandom, len, 2'($urandom_range(0, 2)));
            wait_done();
            chk("rand_nbeats", data_log.size(), int'(len) + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog");
    end

endmodule
